led_pattern_counter: RTL and testbench
======================================

Name: led_pattern_counter

Overview:
Parametrised LED pattern generator for the Mimas Spartan-6 board and the next generation of the board's button-adjustable LED counter. It advances a WIDTH-bit LED pattern once per programmable interval, counted in milliseconds. Four modes are available: binary up, binary down, bouncing single bit, and Gray code. Four active-low board buttons are debounced internally and select faster, slower, next mode, and clear. It sits directly between the board pins and the top level.

Parameters:
WIDTH, 8, LED pattern width (>=2)
CLKS_PER_MS, 100000, clock cycles per millisecond
INTERVAL_DEF_MS, 100, interval after reset/clear
INTERVAL_STEP_MS, 10, change per faster/slower press
INTERVAL_MIN_MS, 10, lower interval bound (>=1)
INTERVAL_MAX_MS, 1000, upper interval bound
DEBOUNCE_MS, 20, ms a raw button level must be stable before it is accepted

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
BTN_FASTER_N  input  1  raw button, low = pressed; shortens interval
BTN_SLOWER_N  input  1  raw button, low = pressed; lengthens interval
BTN_MODE_N  input  1  raw button, low = pressed; next mode
BTN_CLR_N  input  1  raw button, low = pressed; restart pattern and restore default interval
LED  output  WIDTH  current pattern
MODE  output  2  current mode: 0 UP, 1 DOWN, 2 BOUNCE, 3 GRAY
INTERVAL_MS  output  IW  current interval, where IW = $clog2(INTERVAL_MAX_MS+1)
STEP  output  1  one-cycle pulse in the cycle LED advances

Behaviour:
- Reset (RST high): takes effect asynchronously, with no clock edge required.
  - LED=0, MODE=0, INTERVAL_MS=INTERVAL_DEF_MS, STEP=0.
  - All counters are 0; all debounced levels read "released" (1).
- Prescaler: counts 0..CLKS_PER_MS-1 and wraps. ms_tick is high in the wrap cycle.
- Interval counter (ms_cnt):
  - Increments on ms_tick.
  - On ms_tick with ms_cnt >= INTERVAL_MS-1: STEP=1 and ms_cnt clears.
  - Consequence: if the interval shrinks below ms_cnt, the step fires on the next ms_tick.
- Debounce, per button:
  - 2-FF synchroniser.
  - Stability counter counts ms_ticks while the synchronised value differs from the accepted level; it clears whenever the values match.
  - After DEBOUNCE_MS ticks the accepted level updates.
  - Press event = one-cycle pulse, in the cycle after the accepted level goes 1->0.
  - Holding a button gives one event only; release produces no event.
- Mode advance on each step (register update in the STEP cycle):
  - UP: LED+1, wrapping all-ones->0.
  - DOWN: LED-1, wrapping 0->all-ones.
  - BOUNCE: exactly one bit set; shifts left while dir=left. On reaching the MSB, dir flips and the next step moves right; on reaching the LSB, dir flips back to left.
  - GRAY: internal binary counter bin+1 (wraps); LED = bin ^ (bin>>1).
- Initial pattern per mode: UP 0; DOWN all-ones; BOUNCE 1 with dir=left; GRAY bin=0, LED=0.
- Button actions:
  - Faster: INTERVAL_MS -= STEP, saturating at INTERVAL_MIN_MS.
  - Slower: INTERVAL_MS += STEP, saturating at INTERVAL_MAX_MS.
  - Arithmetic is done at IW+1 bits to avoid wrap.
  - Interval changes do not reset ms_cnt or the prescaler.
- Priority within one cycle: CLR > MODE > (FASTER/SLOWER) and the LED step.
  - CLR: LED = initial pattern of the current mode; INTERVAL_MS = DEF; ms_cnt and prescaler = 0; STEP suppressed; MODE unchanged.
  - MODE: MODE = MODE+1 (3 wraps to 0); LED = initial pattern of the new mode; ms_cnt and prescaler = 0; STEP suppressed.
  - FASTER and SLOWER events in the same cycle: both ignored.
  - A faster/slower event coinciding with STEP: both take effect.
- Latency:
  - From a raw edge, the event appears 2 (sync) + DEBOUNCE_MS ms + 1 cycles later.
  - The register update is visible the cycle after the event.
- Parameter sanity: MIN <= DEF <= MAX; elaboration-time assertion fails otherwise.

Decomposition:
- Package led_pattern_pkg holds:
  - mode encoding constants MODE_UP/DOWN/BOUNCE/GRAY;
  - IW computation function;
  - initial-pattern function init_pattern(mode, WIDTH).
- Sub-module btn_debounce (params: DEBOUNCE_MS; inputs: ms_tick, raw_n; outputs: level, press) is instantiated four times.
- Prescaler, interval counter and pattern logic stay in the top.

Test Plan:
Bench parameters: WIDTH=4, CLKS_PER_MS=4, DEF=5, STEP_MS=2, MIN=1, MAX=9, DEBOUNCE_MS=2.
1. Release reset, no buttons -> STEP every 20 cycles; LED 0,1,..,15,0; MODE=0, INTERVAL_MS=5.
2. FASTER low for 1 cycle (glitch) -> no change. Held 4 ms -> one event, INTERVAL_MS=3. Two more presses -> 1 then 1 (saturates). SLOWER x5 from 1 -> 3,5,7,9,9.
3. MODE presses -> MODE=1, LED=15, then steps give 14,13. MODE=2: LED 0001,0010,0100,1000,0100,0010,0001,0010. MODE=3: LED 0,1,3,2,6,7,5,4. Fourth press -> MODE=0, LED=0.
4. In BOUNCE at LED=0100 with INTERVAL_MS=9, press CLR -> LED=0001, dir=left, INTERVAL_MS=5, MODE=2, no STEP that cycle; next STEP exactly 20 cycles later.
5. FASTER and SLOWER pressed in the same cycle -> INTERVAL_MS unchanged. CLR and MODE pressed in the same cycle -> CLR wins, MODE unchanged.
6. Assert RST mid-interval, between clock edges -> LED=0, MODE=0, INTERVAL_MS=5, STEP=0 immediately. After release, first STEP occurs 20 cycles later.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared definitions for the LED pattern counter:
//   - MODE_* : two-bit encodings of the four pattern modes
//   - calc_iw      : width of the interval register for a given maximum (ms)
//   - init_pattern : LED value a mode starts from (after CLR or a mode change)
// -----------------------------------------------------------------------------
package led_pattern_pkg;

   localparam logic [1:0] MODE_UP     = 2'd0;
   localparam logic [1:0] MODE_DOWN   = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_GRAY   = 2'd3;

   // Bits needed to hold 0..max_ms inclusive.
   function automatic int calc_iw(input int max_ms);
      if (max_ms < 1) begin
         return 1;
      end else begin
         return $clog2(max_ms + 1);
      end
   endfunction

   // Starting pattern of a mode, LSB-aligned in 64 bits; callers truncate to
   // their own width. DOWN starts from all-ones of the requested width.
   function automatic logic [63:0] init_pattern(input logic [1:0] mode, input int width);
      logic [63:0] w_pat;
      case (mode)
         MODE_UP:     w_pat = 64'd0;
         MODE_DOWN:   w_pat = {64{1'b1}} >> (64 - width);
         MODE_BOUNCE: w_pat = 64'd1;
         MODE_GRAY:   w_pat = 64'd0;
         default:     w_pat = 64'd0;
      endcase
      return w_pat;
   endfunction

endpackage

// File: rtl/led_pattern_counter_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Debounces one active-low raw button.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_ms_tick    : one-cycle pulse per millisecond
//   i_raw_n      : raw pin level, low = pressed
//   o_level      : accepted (debounced) level, reset value 1 (released)
//   o_press      : one-cycle pulse when the accepted level falls 1->0
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_MS = 20
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ms_tick,
   input  logic i_raw_n,
   output logic o_level,
   output logic o_press
);

   localparam int CW = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_MS - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // Two-flop synchroniser for the asynchronous pin.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_raw_n;
         r_sync2 <= r_sync1;
      end
   end

   // Stability counter: ms ticks spent disagreeing with the accepted level.
   // Any agreement restarts the count, so only a continuously stable new
   // level is accepted. The press pulse rides along with a 1->0 acceptance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_level <= 1'b1;
         r_press <= 1'b0;
      end else begin
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (i_ms_tick) begin
            if (r_cnt == C_LAST) begin
               r_cnt   <= '0;
               r_level <= r_sync2;
               r_press <= ~r_sync2;
            end else begin
               r_cnt <= r_cnt + C_ONE;
            end
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/led_pattern_counter.sv
// -----------------------------------------------------------------------------
// led_pattern_counter
// Button-adjustable LED pattern generator. The pattern advances once every
// INTERVAL_MS milliseconds in one of four modes (UP, DOWN, BOUNCE, GRAY).
//   CLK, RST      : clock, asynchronous active-high reset
//   BTN_FASTER_N  : raw button, shortens the interval
//   BTN_SLOWER_N  : raw button, lengthens the interval
//   BTN_MODE_N    : raw button, selects the next mode
//   BTN_CLR_N     : raw button, restarts the pattern and default interval
//   LED           : current pattern
//   MODE          : current mode (0 UP, 1 DOWN, 2 BOUNCE, 3 GRAY)
//   INTERVAL_MS   : current interval in ms
//   STEP          : one-cycle pulse in the cycle LED advances
// -----------------------------------------------------------------------------
module led_pattern_counter
   import led_pattern_pkg::*;
#(
   parameter int  WIDTH            = 8,
   parameter int  CLKS_PER_MS      = 100000,
   parameter int  INTERVAL_DEF_MS  = 100,
   parameter int  INTERVAL_STEP_MS = 10,
   parameter int  INTERVAL_MIN_MS  = 10,
   parameter int  INTERVAL_MAX_MS  = 1000,
   parameter int  DEBOUNCE_MS      = 20,
   localparam int IW               = calc_iw(INTERVAL_MAX_MS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             BTN_FASTER_N,
   input  logic             BTN_SLOWER_N,
   input  logic             BTN_MODE_N,
   input  logic             BTN_CLR_N,
   output logic [WIDTH-1:0] LED,
   output logic [1:0]       MODE,
   output logic [IW-1:0]    INTERVAL_MS,
   output logic             STEP
);

   localparam int EW = IW + 1;
   localparam int PW = (CLKS_PER_MS < 2) ? 1 : $clog2(CLKS_PER_MS);

   localparam logic [PW-1:0]    C_PRESC_LAST = PW'(CLKS_PER_MS - 1);
   localparam logic [PW-1:0]    C_PRESC_ONE  = PW'(1);
   localparam logic [IW-1:0]    C_MS_ONE     = IW'(1);
   localparam logic [IW-1:0]    C_DEF        = IW'(INTERVAL_DEF_MS);
   localparam logic [EW-1:0]    C_EXT_ONE    = EW'(1);
   localparam logic [EW-1:0]    C_MIN_E      = EW'(INTERVAL_MIN_MS);
   localparam logic [EW-1:0]    C_MAX_E      = EW'(INTERVAL_MAX_MS);
   localparam logic [EW-1:0]    C_STEP_E     = EW'(INTERVAL_STEP_MS);
   localparam logic [WIDTH-1:0] C_LED_ONE    = WIDTH'(1);

   if (INTERVAL_MIN_MS < 1 || INTERVAL_MIN_MS > INTERVAL_DEF_MS ||
       INTERVAL_DEF_MS > INTERVAL_MAX_MS || WIDTH < 2 || WIDTH > 64) begin : g_bad_params
      $error("led_pattern_counter: illegal parameter combination");
   end

   logic [PW-1:0]    r_presc;
   logic [IW-1:0]    r_ms_cnt;
   logic [IW-1:0]    r_interval;
   logic [WIDTH-1:0] r_led;
   logic [WIDTH-1:0] r_bin;
   logic [1:0]       r_mode;
   logic             r_dir;       // 1 = moving toward the MSB
   logic             r_step;

   logic [3:0]       w_levels_unused;
   logic             w_fast_press;
   logic             w_slow_press;
   logic             w_mode_press;
   logic             w_clr_press;
   logic             w_ms_tick;
   logic             w_step_due;
   logic [1:0]       w_mode_inc;
   logic [WIDTH-1:0] w_init_cur;
   logic [WIDTH-1:0] w_init_new;
   logic [WIDTH-1:0] w_adv_led;
   logic [WIDTH-1:0] w_adv_bin;
   logic             w_adv_dir;
   logic [EW-1:0]    w_int_ext;
   logic [EW-1:0]    w_faster;
   logic [EW-1:0]    w_slower;
   logic [PW-1:0]    w_presc_nxt;
   logic [IW-1:0]    w_ms_nxt;
   logic [IW-1:0]    w_int_nxt;
   logic [WIDTH-1:0] w_led_nxt;
   logic [WIDTH-1:0] w_bin_nxt;
   logic [1:0]       w_mode_nxt;
   logic             w_dir_nxt;
   logic             w_step_nxt;

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_faster (
      .i_clk(CLK), .i_rst(RST), .i_ms_tick(w_ms_tick), .i_raw_n(BTN_FASTER_N),
      .o_level(w_levels_unused[0]), .o_press(w_fast_press));
   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_slower (
      .i_clk(CLK), .i_rst(RST), .i_ms_tick(w_ms_tick), .i_raw_n(BTN_SLOWER_N),
      .o_level(w_levels_unused[1]), .o_press(w_slow_press));
   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
      .i_clk(CLK), .i_rst(RST), .i_ms_tick(w_ms_tick), .i_raw_n(BTN_MODE_N),
      .o_level(w_levels_unused[2]), .o_press(w_mode_press));
   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clr (
      .i_clk(CLK), .i_rst(RST), .i_ms_tick(w_ms_tick), .i_raw_n(BTN_CLR_N),
      .o_level(w_levels_unused[3]), .o_press(w_clr_press));

   assign w_ms_tick  = (r_presc == C_PRESC_LAST);
   // ms_cnt >= INTERVAL_MS-1, rewritten as ms_cnt+1 >= INTERVAL_MS so that a
   // shrunken interval fires on the next tick without any subtraction.
   assign w_step_due = w_ms_tick && (({1'b0, r_ms_cnt} + C_EXT_ONE) >= {1'b0, r_interval});
   assign w_mode_inc = r_mode + 2'd1;
   assign w_init_cur = WIDTH'(init_pattern(r_mode, WIDTH));
   assign w_init_new = WIDTH'(init_pattern(w_mode_inc, WIDTH));
   assign w_int_ext  = {1'b0, r_interval};

   // Pattern value (and bounce direction / Gray counter) after one step.
   always_comb begin
      w_adv_led = r_led;
      w_adv_dir = r_dir;
      w_adv_bin = r_bin;
      case (r_mode)
         MODE_UP:   w_adv_led = r_led + C_LED_ONE;
         MODE_DOWN: w_adv_led = r_led - C_LED_ONE;
         MODE_BOUNCE: begin
            // Direction flips as the lit bit lands on an end position.
            if (r_dir) begin
               w_adv_led = r_led << 1;
               if (r_led[WIDTH-2]) begin
                  w_adv_dir = 1'b0;
               end else begin
                  w_adv_dir = 1'b1;
               end
            end else begin
               w_adv_led = r_led >> 1;
               if (r_led[1]) begin
                  w_adv_dir = 1'b1;
               end else begin
                  w_adv_dir = 1'b0;
               end
            end
         end
         MODE_GRAY: begin
            w_adv_bin = r_bin + C_LED_ONE;
            w_adv_led = w_adv_bin ^ (w_adv_bin >> 1);
         end
         default: w_adv_led = r_led;
      endcase
   end

   // Saturating interval adjustments, one bit wider than the register.
   always_comb begin
      if (w_int_ext < (C_MIN_E + C_STEP_E)) begin
         w_faster = C_MIN_E;
      end else begin
         w_faster = w_int_ext - C_STEP_E;
      end
      if ((w_int_ext + C_STEP_E) > C_MAX_E) begin
         w_slower = C_MAX_E;
      end else begin
         w_slower = w_int_ext + C_STEP_E;
      end
   end

   // Next-state selection: CLR beats MODE, which beats stepping and
   // interval changes; the latter two may coincide.
   always_comb begin
      w_presc_nxt = r_presc;
      w_ms_nxt    = r_ms_cnt;
      w_int_nxt   = r_interval;
      w_led_nxt   = r_led;
      w_bin_nxt   = r_bin;
      w_mode_nxt  = r_mode;
      w_dir_nxt   = r_dir;
      w_step_nxt  = 1'b0;
      if (w_clr_press) begin
         w_presc_nxt = '0;
         w_ms_nxt    = '0;
         w_int_nxt   = C_DEF;
         w_led_nxt   = w_init_cur;
         w_bin_nxt   = '0;
         w_dir_nxt   = 1'b1;
      end else if (w_mode_press) begin
         w_presc_nxt = '0;
         w_ms_nxt    = '0;
         w_mode_nxt  = w_mode_inc;
         w_led_nxt   = w_init_new;
         w_bin_nxt   = '0;
         w_dir_nxt   = 1'b1;
      end else begin
         if (w_ms_tick) begin
            w_presc_nxt = '0;
         end else begin
            w_presc_nxt = r_presc + C_PRESC_ONE;
         end
         if (w_step_due) begin
            w_ms_nxt   = '0;
            w_step_nxt = 1'b1;
            w_led_nxt  = w_adv_led;
            w_bin_nxt  = w_adv_bin;
            w_dir_nxt  = w_adv_dir;
         end else if (w_ms_tick) begin
            w_ms_nxt = r_ms_cnt + C_MS_ONE;
         end else begin
            w_ms_nxt = r_ms_cnt;
         end
         if (w_fast_press && !w_slow_press) begin
            w_int_nxt = w_faster[IW-1:0];
         end else if (w_slow_press && !w_fast_press) begin
            w_int_nxt = w_slower[IW-1:0];
         end else begin
            w_int_nxt = r_interval;
         end
      end
   end

   // State registers; reset lands in UP mode at the default interval.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_presc    <= '0;
         r_ms_cnt   <= '0;
         r_interval <= C_DEF;
         r_led      <= '0;
         r_bin      <= '0;
         r_mode     <= MODE_UP;
         r_dir      <= 1'b1;
         r_step     <= 1'b0;
      end else begin
         r_presc    <= w_presc_nxt;
         r_ms_cnt   <= w_ms_nxt;
         r_interval <= w_int_nxt;
         r_led      <= w_led_nxt;
         r_bin      <= w_bin_nxt;
         r_mode     <= w_mode_nxt;
         r_dir      <= w_dir_nxt;
         r_step     <= w_step_nxt;
      end
   end

   assign LED         = r_led;
   assign MODE        = r_mode;
   assign INTERVAL_MS = r_interval;
   assign STEP        = r_step;

endmodule

// File: tb/tb_led_pattern_counter.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_counter
// Directed scenarios followed by random button traffic. A reference model
// tracks the number of steps since the pattern last restarted and derives the
// expected LED arithmetically from the mode.
// -----------------------------------------------------------------------------
module tb_led_pattern_counter;

   localparam int W    = 4;
   localparam int CPM  = 4;
   localparam int DEF  = 5;
   localparam int STP  = 2;
   localparam int MINV = 1;
   localparam int MAXV = 9;
   localparam int DB   = 2;
   localparam int IW   = 4;

   localparam int M_FAST = 1;
   localparam int M_SLOW = 2;
   localparam int M_MODE = 4;
   localparam int M_CLR  = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          bf  = 1'b1;
   logic          bs  = 1'b1;
   logic          bm  = 1'b1;
   logic          bc  = 1'b1;
   logic [W-1:0]  led;
   logic [1:0]    mode;
   logic [IW-1:0] intv;
   logic          step;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int m_presc, m_ms, m_int, m_mode, m_k;
   bit m_step;
   bit s1 [4];
   bit s2 [4];
   bit lvl [4];
   int cnt [4];
   bit prs [4];

   led_pattern_counter #(
      .WIDTH(W), .CLKS_PER_MS(CPM), .INTERVAL_DEF_MS(DEF), .INTERVAL_STEP_MS(STP),
      .INTERVAL_MIN_MS(MINV), .INTERVAL_MAX_MS(MAXV), .DEBOUNCE_MS(DB)
   ) dut (
      .CLK(CLK), .RST(RST), .BTN_FASTER_N(bf), .BTN_SLOWER_N(bs),
      .BTN_MODE_N(bm), .BTN_CLR_N(bc), .LED(led), .MODE(mode),
      .INTERVAL_MS(intv), .STEP(step)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] exp_led(input int md, input int k);
      int p, pos, g;
      case (md)
         0: return W'(k % (1 << W));
         1: return W'((1 << W) - 1 - (k % (1 << W)));
         2: begin
            p   = k % (2 * W - 2);
            pos = (p < W) ? p : (2 * W - 2 - p);
            return W'(1 << pos);
         end
         default: begin
            g = k % (1 << W);
            return W'(g ^ (g >> 1));
         end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_presc = 0; m_ms = 0; m_int = DEF; m_mode = 0; m_k = 0; m_step = 1'b0;
      for (int b = 0; b < 4; b++) begin
         s1[b] = 1'b1; s2[b] = 1'b1; lvl[b] = 1'b1; cnt[b] = 0; prs[b] = 1'b0;
      end
   endtask

   task automatic model_update();
      bit tick, pf, ps, pm, pc;
      bit raw [4];
      raw[0] = bf; raw[1] = bs; raw[2] = bm; raw[3] = bc;
      tick = (m_presc == CPM - 1);
      pf = prs[0]; ps = prs[1]; pm = prs[2]; pc = prs[3];
      for (int b = 0; b < 4; b++) begin
         prs[b] = 1'b0;
         if (s2[b] == lvl[b]) begin
            cnt[b] = 0;
         end else if (tick) begin
            cnt[b]++;
            if (cnt[b] == DB) begin
               lvl[b] = s2[b];
               cnt[b] = 0;
               prs[b] = ~s2[b];
            end
         end
         s2[b] = s1[b];
         s1[b] = raw[b];
      end
      m_step = 1'b0;
      if (pc) begin
         m_k = 0; m_int = DEF; m_ms = 0; m_presc = 0;
      end else if (pm) begin
         m_mode = (m_mode + 1) % 4; m_k = 0; m_ms = 0; m_presc = 0;
      end else begin
         m_presc = tick ? 0 : m_presc + 1;
         if (tick) begin
            if (m_ms + 1 >= m_int) begin
               m_ms = 0; m_step = 1'b1; m_k++;
            end else begin
               m_ms++;
            end
         end
         if (pf && !ps) m_int = (m_int - STP < MINV) ? MINV : m_int - STP;
         else if (ps && !pf) m_int = (m_int + STP > MAXV) ? MAXV : m_int + STP;
      end
   endtask

   // One clock: advance the model with the inputs the DUT sees, then compare.
   task automatic cyc();
      @(posedge CLK);
      if (RST) model_reset();
      else model_update();
      #1;
      chk("led", led, exp_led(m_mode, m_k));
      chk("mode", mode, m_mode);
      chk("interval", intv, m_int);
      chk("step", step, m_step);
   endtask

   task automatic wait_step(input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (step !== 1'b1 && n < budget);
   endtask

   task automatic drive(input int mask, input logic v);
      if (mask & M_FAST) bf = v;
      if (mask & M_SLOW) bs = v;
      if (mask & M_MODE) bm = v;
      if (mask & M_CLR)  bc = v;
   endtask

   task automatic press(input int mask, input int hold, input int settle);
      drive(mask, 1'b0);
      repeat (hold) cyc();
      drive(mask, 1'b1);
      repeat (settle) cyc();
   endtask

   int n;
   int exp_b [7] = '{2, 4, 8, 4, 2, 1, 2};
   int exp_g [7] = '{1, 3, 2, 6, 7, 5, 4};
   int exp_s [5] = '{3, 5, 7, 9, 9};

   initial begin
      model_reset();
      // reset applied between edges, visible without a clock
      #1 RST = 1'b1;
      #1;
      chk("rst_led", led, 0);
      chk("rst_mode", mode, 0);
      chk("rst_interval", intv, DEF);
      chk("rst_step", step, 0);
      cyc(); cyc();
      #2 RST = 1'b0;

      // free-running UP count, one step per 20 cycles
      for (int i = 1; i <= 17; i++) begin
         wait_step(40, n);
         chk("up_gap", n, 20);
         chk("up_led", led, i % 16);
      end

      // glitch, then faster/slower saturation
      press(M_FAST, 1, 40);
      chk("glitch_interval", intv, 5);
      press(M_FAST, 16, 12); chk("faster1", intv, 3);
      press(M_FAST, 16, 12); chk("faster2", intv, 1);
      press(M_FAST, 16, 12); chk("faster_sat", intv, 1);
      for (int i = 0; i < 5; i++) begin
         press(M_SLOW, 16, 12);
         chk("slower", intv, exp_s[i]);
      end

      // mode walk
      press(M_MODE, 16, 12);
      chk("down_mode", mode, 1); chk("down_init", led, 15);
      wait_step(60, n); chk("down1", led, 14);
      wait_step(60, n); chk("down2", led, 13);
      press(M_MODE, 16, 12);
      chk("bounce_mode", mode, 2); chk("bounce_init", led, 1);
      for (int i = 0; i < 7; i++) begin
         wait_step(60, n);
         chk("bounce", led, exp_b[i]);
      end
      press(M_MODE, 16, 12);
      chk("gray_mode", mode, 3); chk("gray_init", led, 0);
      for (int i = 0; i < 7; i++) begin
         wait_step(60, n);
         chk("gray", led, exp_g[i]);
      end
      press(M_MODE, 16, 12);
      chk("wrap_mode", mode, 0); chk("wrap_led", led, 0);

      // CLR in BOUNCE with interval 9
      press(M_MODE, 16, 12);
      press(M_MODE, 16, 12);
      wait_step(60, n); wait_step(60, n);
      bc = 1'b0;
      n = 0;
      do begin
         cyc();
         n++;
      end while (intv !== 4'd5 && n < 40);
      chk("clr_interval", intv, 5);
      chk("clr_led", led, 1);
      chk("clr_mode", mode, 2);
      chk("clr_step", step, 0);
      wait_step(40, n);
      chk("clr_gap", n, 20);
      bc = 1'b1;
      repeat (12) cyc();

      // simultaneous presses
      press(M_FAST | M_SLOW, 16, 12);
      chk("fast_slow_same", intv, 5);
      press(M_SLOW, 16, 12);
      chk("slower_pre_clr", intv, 7);
      press(M_CLR | M_MODE, 16, 12);
      chk("clr_beats_mode", mode, 2);
      chk("clr_beats_mode_int", intv, 5);

      // asynchronous reset mid-interval
      cyc();
      #3 RST = 1'b1;
      #1;
      chk("arst_led", led, 0);
      chk("arst_mode", mode, 0);
      chk("arst_interval", intv, DEF);
      chk("arst_step", step, 0);
      cyc(); cyc();
      #2 RST = 1'b0;
      wait_step(40, n);
      chk("arst_gap", n, 20);

      // random button traffic
      for (int i = 0; i < 250; i++) begin
         press($urandom_range(0, 15), $urandom_range(1, 24), $urandom_range(0, 30));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
